// File: rtl/rule_conf_pkg.sv
// Shared sizing, rule-config address map, FSM states and descriptor layout for rule installs.
// Sizing lives here because the descriptor struct and the interface depend on it.
package rule_conf_pkg;

  localparam int TYPE_NUM         = 4;
  localparam int TYPE_WIDTH       = 8;
  localparam int KEY_OFFSET_WIDTH = 6;
  localparam int KEY_FIELD_NUM    = 8;
  localparam int RULE_NUM         = 4;

  localparam int IDX_MAX = (TYPE_NUM > KEY_FIELD_NUM) ? TYPE_NUM : KEY_FIELD_NUM;
  localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
  localparam int TI_W    = (TYPE_NUM > 1) ? $clog2(TYPE_NUM) : 1;
  localparam int KI_W    = (KEY_FIELD_NUM > 1) ? $clog2(KEY_FIELD_NUM) : 1;

  localparam logic [31:0] CONF_RULE_BASE = 32'h0001_0000;
  localparam logic [1:0]  SEL_COMMIT     = 2'b00;
  localparam logic [1:0]  SEL_TYPE       = 2'b01;
  localparam logic [1:0]  SEL_KEY        = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_TYPE,
    ST_WR_KEY,
    ST_COMMIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [5:0]                                     rule_id;
    logic                                           rule_valid;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]            type_data;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]            type_mask;
    logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0] key_offset;
  } desc_t;

  // Address = base | field-select in bits [9:8] | field index in the low bits.
  function automatic logic [31:0] rule_addr(input logic [1:0] sel, input logic [5:0] idx);
    return CONF_RULE_BASE | {22'b0, sel, 8'b0} | {26'b0, idx};
  endfunction

endpackage

// File: rtl/rule_install_sched_if.sv
// Requester descriptor handshakes plus the rule-config write port of the install scheduler.
interface rule_install_sched_if;
  import rule_conf_pkg::*;

  logic                                           i_req0_valid;
  logic                                           o_req0_ready;
  logic [5:0]                                     i_req0_rule_id;
  logic                                           i_req0_rule_valid;
  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]            i_req0_type_data;
  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]            i_req0_type_mask;
  logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0] i_req0_key_offset;
  logic                                           o_req0_done;
  logic                                           o_req0_err;

  logic                                           i_req1_valid;
  logic                                           o_req1_ready;
  logic [5:0]                                     i_req1_rule_id;
  logic                                           i_req1_rule_valid;
  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]            i_req1_type_data;
  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]            i_req1_type_mask;
  logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0] i_req1_key_offset;
  logic                                           o_req1_done;
  logic                                           o_req1_err;

  logic                                           o_rule_wren;
  logic [63:0]                                    o_rule_wdata;
  logic [31:0]                                    o_rule_addr;
  logic                                           o_busy;

  modport master (
    output i_req0_valid, i_req0_rule_id, i_req0_rule_valid, i_req0_type_data,
           i_req0_type_mask, i_req0_key_offset,
           i_req1_valid, i_req1_rule_id, i_req1_rule_valid, i_req1_type_data,
           i_req1_type_mask, i_req1_key_offset,
    input  o_req0_ready, o_req0_done, o_req0_err,
           o_req1_ready, o_req1_done, o_req1_err,
           o_rule_wren, o_rule_wdata, o_rule_addr, o_busy
  );

  modport slave (
    input  i_req0_valid, i_req0_rule_id, i_req0_rule_valid, i_req0_type_data,
           i_req0_type_mask, i_req0_key_offset,
           i_req1_valid, i_req1_rule_id, i_req1_rule_valid, i_req1_type_data,
           i_req1_type_mask, i_req1_key_offset,
    output o_req0_ready, o_req0_done, o_req0_err,
           o_req1_ready, o_req1_done, o_req1_err,
           o_rule_wren, o_rule_wdata, o_rule_addr, o_busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; combinational grant, last_grant updates on accept.
// Ties go to the requester that did not win last; after reset requester 0 wins first.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_grant)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/rule_install_sched.sv
// Serializes arbitrated rule descriptors into type, key, then commit writes (13 writes, done at T+14).
// Ready only in IDLE for the granted requester; write port outputs are registered.
module rule_install_sched
  import rule_conf_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  rule_install_sched_if.slave  bus
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  desc_t            desc_q, desc_d, desc0, desc1;
  logic             owner_q, owner_d, err_q, err_d;
  logic [1:0]       req, gnt;
  logic             accept;
  logic             wren_d, wren_q;
  logic [31:0]      addr_d, addr_q;
  logic [63:0]      wdata_d, wdata_q;
  logic [1:0]       done_q, err_out_q;

  assign desc0 = '{rule_id: bus.i_req0_rule_id, rule_valid: bus.i_req0_rule_valid,
                   type_data: bus.i_req0_type_data, type_mask: bus.i_req0_type_mask,
                   key_offset: bus.i_req0_key_offset};
  assign desc1 = '{rule_id: bus.i_req1_rule_id, rule_valid: bus.i_req1_rule_valid,
                   type_data: bus.i_req1_type_data, type_mask: bus.i_req1_type_mask,
                   key_offset: bus.i_req1_key_offset};

  assign req    = {bus.i_req1_valid, bus.i_req0_valid} & {2{state_q == ST_IDLE}};
  assign accept = |gnt;

  rr_arb2 u_arb (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  // Ready is masked during reset so every output reads 0 while i_rst is high.
  assign bus.o_req0_ready = gnt[0] & ~i_rst;
  assign bus.o_req1_ready = gnt[1] & ~i_rst;
  assign bus.o_rule_wren  = wren_q;
  assign bus.o_rule_addr  = addr_q;
  assign bus.o_rule_wdata = wdata_q;
  assign bus.o_req0_done  = done_q[0];
  assign bus.o_req1_done  = done_q[1];
  assign bus.o_req0_err   = err_out_q[0];
  assign bus.o_req1_err   = err_out_q[1];
  assign bus.o_busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    desc_d  = desc_q;
    owner_d = owner_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = gnt[1];
          desc_d  = gnt[1] ? desc1 : desc0;
          idx_d   = '0;
          err_d   = (int'(desc_d.rule_id) >= RULE_NUM);
          state_d = err_d ? ST_DONE : ST_WR_TYPE;
        end
      end
      ST_WR_TYPE: begin
        if (idx_q == IDX_W'(TYPE_NUM - 1)) begin
          state_d = ST_WR_KEY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_WR_KEY: begin
        if (idx_q == IDX_W'(KEY_FIELD_NUM - 1)) begin
          state_d = ST_COMMIT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_COMMIT: begin
        state_d = ST_DONE;
        idx_d   = '0;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Write port is computed from the next state so the first write lands the cycle after accept.
  always_comb begin
    wren_d  = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    case (state_d)
      ST_WR_TYPE: begin
        wren_d                   = 1'b1;
        addr_d                   = rule_addr(SEL_TYPE, 6'(idx_d));
        wdata_d[32 +: TYPE_WIDTH] = desc_d.type_data[idx_d[TI_W-1:0]];
        wdata_d[0 +: TYPE_WIDTH]  = desc_d.type_mask[idx_d[TI_W-1:0]];
      end
      ST_WR_KEY: begin
        wren_d                         = 1'b1;
        addr_d                         = rule_addr(SEL_KEY, 6'(idx_d));
        wdata_d[0 +: KEY_OFFSET_WIDTH] = desc_d.key_offset[idx_d[KI_W-1:0]];
      end
      ST_COMMIT: begin
        wren_d  = 1'b1;
        addr_d  = rule_addr(SEL_COMMIT, desc_d.rule_id);
        wdata_d = {63'b0, desc_d.rule_valid};
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      desc_q    <= '0;
      owner_q   <= 1'b0;
      err_q     <= 1'b0;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 2'b00;
      err_out_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      desc_q    <= desc_d;
      owner_q   <= owner_d;
      err_q     <= err_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      done_q    <= (state_d == ST_DONE) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
      err_out_q <= (state_d == ST_DONE && err_d) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    end
  end

endmodule

// File: tb/tb_rule_install_sched.sv
// Directed bench for rule_install_sched: hand-computed write sequences, grant order and timing.
module tb_rule_install_sched;
  import rule_conf_pkg::*;

  typedef logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]            tvec_t;
  typedef logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0] kvec_t;

  localparam tvec_t A_DATA = {8'h08, 8'h06, 8'h11, 8'h86};
  localparam tvec_t A_MASK = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
  localparam kvec_t A_KEY  = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
  localparam tvec_t B_DATA = {8'h44, 8'h33, 8'hAB, 8'h11};
  localparam tvec_t B_MASK = {8'hFF, 8'h00, 8'h0F, 8'hF0};
  localparam kvec_t B_KEY  = {6'd56, 6'd57, 6'd58, 6'd59, 6'd60, 6'd61, 6'd62, 6'd63};

  logic i_clk = 1'b0;
  logic i_rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] wr_addr[$];
  logic [63:0] wr_data[$];
  int          wr_cyc[$];
  int          acc_cyc[$], acc_who[$];
  int          done_cyc[$], done_who[$], done_err[$];
  int          busy_cnt = 0, both_rdy = 0, idle_nz = 0, stray_err = 0;
  logic [63:0] exp_type[TYPE_NUM];
  logic [63:0] exp_key[KEY_FIELD_NUM];

  rule_install_sched_if bus ();

  rule_install_sched dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Record everything at the falling edge, half a cycle away from the active edge.
  always @(negedge i_clk) begin
    if (bus.o_rule_wren) begin
      wr_addr.push_back(bus.o_rule_addr);
      wr_data.push_back(bus.o_rule_wdata);
      wr_cyc.push_back(cyc);
    end else if (bus.o_rule_addr != 32'h0 || bus.o_rule_wdata != 64'h0) begin
      idle_nz <= idle_nz + 1;
    end
    if (bus.o_req0_ready && bus.i_req0_valid) begin
      acc_cyc.push_back(cyc);
      acc_who.push_back(0);
    end
    if (bus.o_req1_ready && bus.i_req1_valid) begin
      acc_cyc.push_back(cyc);
      acc_who.push_back(1);
    end
    if (bus.o_req0_ready && bus.o_req1_ready) both_rdy <= both_rdy + 1;
    if (bus.o_req0_done) begin
      done_cyc.push_back(cyc);
      done_who.push_back(0);
      done_err.push_back(int'(bus.o_req0_err));
    end
    if (bus.o_req1_done) begin
      done_cyc.push_back(cyc);
      done_who.push_back(1);
      done_err.push_back(int'(bus.o_req1_err));
    end
    if ((bus.o_req0_err && !bus.o_req0_done) || (bus.o_req1_err && !bus.o_req1_done))
      stray_err <= stray_err + 1;
    if (bus.o_busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic set_req(input int n, input logic vld, input logic [5:0] id, input logic rv,
                         input tvec_t d, input tvec_t m, input kvec_t k);
    if (n == 0) begin
      bus.i_req0_valid = vld; bus.i_req0_rule_id = id; bus.i_req0_rule_valid = rv;
      bus.i_req0_type_data = d; bus.i_req0_type_mask = m; bus.i_req0_key_offset = k;
    end else begin
      bus.i_req1_valid = vld; bus.i_req1_rule_id = id; bus.i_req1_rule_valid = rv;
      bus.i_req1_type_data = d; bus.i_req1_type_mask = m; bus.i_req1_key_offset = k;
    end
  endtask

  task automatic wait_acc(input int n, input int budget);
    int i = 0;
    while (acc_cyc.size() < n && i < budget) begin
      step(1);
      i++;
    end
    if (acc_cyc.size() < n) chk("accept_timeout", acc_cyc.size(), n);
  endtask

  task automatic wait_done(input int n, input int budget);
    int i = 0;
    while (done_cyc.size() < n && i < budget) begin
      step(1);
      i++;
    end
    if (done_cyc.size() < n) chk("done_timeout", done_cyc.size(), n);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wren"},  bus.o_rule_wren,  1'b0);
    chk({tag, "_addr"},  bus.o_rule_addr,  32'h0);
    chk({tag, "_wdata"}, bus.o_rule_wdata, 64'h0);
    chk({tag, "_busy"},  bus.o_busy,       1'b0);
    chk({tag, "_rdy0"},  bus.o_req0_ready, 1'b0);
    chk({tag, "_rdy1"},  bus.o_req1_ready, 1'b0);
    chk({tag, "_done"},  {bus.o_req1_done, bus.o_req0_done}, 2'b00);
    chk({tag, "_err"},   {bus.o_req1_err, bus.o_req0_err}, 2'b00);
  endtask

  task automatic load_exp_a();
    exp_type[0] = 64'h0000_0086_0000_00FF;
    exp_type[1] = 64'h0000_0011_0000_00FF;
    exp_type[2] = 64'h0000_0006_0000_00FF;
    exp_type[3] = 64'h0000_0008_0000_00FF;
    for (int k = 0; k < KEY_FIELD_NUM; k++) exp_key[k] = 64'(k);
  endtask

  task automatic load_exp_b();
    exp_type[0] = 64'h0000_0011_0000_00F0;
    exp_type[1] = 64'h0000_00AB_0000_000F;
    exp_type[2] = 64'h0000_0033_0000_0000;
    exp_type[3] = 64'h0000_0044_0000_00FF;
    for (int k = 0; k < KEY_FIELD_NUM; k++) exp_key[k] = 64'(63 - k);
  endtask

  task automatic check_install(input string tag, input int wb, input int ai, input int di,
                               input int who, input logic [31:0] caddr, input logic [63:0] cdata);
    int t;
    if (wr_addr.size() < wb + 13) begin
      chk({tag, "_nwr"}, wr_addr.size(), wb + 13);
      return;
    end
    if (acc_cyc.size() <= ai) begin
      chk({tag, "_nacc"}, acc_cyc.size(), ai + 1);
      return;
    end
    if (done_cyc.size() <= di) begin
      chk({tag, "_ndone"}, done_cyc.size(), di + 1);
      return;
    end
    t = acc_cyc[ai];
    chk({tag, "_acc_who"}, acc_who[ai], who);
    chk({tag, "_first_cyc"}, wr_cyc[wb], t + 1);
    for (int i = 0; i < TYPE_NUM; i++) begin
      chk({tag, "_type_addr"}, wr_addr[wb + i], 32'h0001_0100 + i);
      chk({tag, "_type_data"}, wr_data[wb + i], exp_type[i]);
    end
    for (int k = 0; k < KEY_FIELD_NUM; k++) begin
      chk({tag, "_key_addr"}, wr_addr[wb + 4 + k], 32'h0001_0200 + k);
      chk({tag, "_key_data"}, wr_data[wb + 4 + k], exp_key[k]);
    end
    chk({tag, "_commit_addr"}, wr_addr[wb + 12], caddr);
    chk({tag, "_commit_data"}, wr_data[wb + 12], cdata);
    chk({tag, "_commit_cyc"}, wr_cyc[wb + 12], t + 13);
    chk({tag, "_done_cyc"}, done_cyc[di], t + 14);
    chk({tag, "_done_who"}, done_who[di], who);
    chk({tag, "_done_err"}, done_err[di], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int wb, ab, db, bb, i;
    i_rst = 1'b1;
    set_req(0, 1'b0, 6'd0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 6'd0, 1'b0, '0, '0, '0);
    #1;
    chk_zero("reset");
    step(2);
    i_rst = 1'b0;
    step(1);

    // Single install from requester 0; inputs scrambled after accept.
    wb = wr_addr.size(); ab = acc_cyc.size(); db = done_cyc.size();
    set_req(0, 1'b1, 6'd2, 1'b1, A_DATA, A_MASK, A_KEY);
    wait_acc(ab + 1, 10);
    set_req(0, 1'b0, 6'd9, 1'b0, '0, '0, '1);
    wait_done(db + 1, 40);
    step(3);
    load_exp_a();
    check_install("single", wb, ab, db, 0, 32'h0001_0002, 64'h1);
    chk("single_nwr", wr_addr.size(), wb + 13);

    // Simultaneous requests right after reset: requester 0 first, then 1 at T+15.
    i_rst = 1'b1;
    step(2);
    i_rst = 1'b0;
    step(1);
    wb = wr_addr.size(); ab = acc_cyc.size(); db = done_cyc.size();
    set_req(0, 1'b1, 6'd1, 1'b1, A_DATA, A_MASK, A_KEY);
    set_req(1, 1'b1, 6'd3, 1'b0, B_DATA, B_MASK, B_KEY);
    wait_acc(ab + 1, 10);
    set_req(0, 1'b0, 6'd1, 1'b1, A_DATA, A_MASK, A_KEY);
    wait_acc(ab + 2, 40);
    set_req(1, 1'b0, 6'd3, 1'b0, B_DATA, B_MASK, B_KEY);
    wait_done(db + 2, 40);
    step(3);
    if (acc_cyc.size() >= ab + 2) chk("both_spacing", acc_cyc[ab + 1] - acc_cyc[ab], 15);
    load_exp_a();
    check_install("both_r0", wb, ab, db, 0, 32'h0001_0001, 64'h1);
    load_exp_b();
    check_install("both_r1", wb + 13, ab + 1, db + 1, 1, 32'h0001_0003, 64'h0);

    // Both held valid: grants alternate 0,1,0 back-to-back.
    wb = wr_addr.size(); ab = acc_cyc.size(); db = done_cyc.size();
    set_req(0, 1'b1, 6'd1, 1'b1, A_DATA, A_MASK, A_KEY);
    set_req(1, 1'b1, 6'd3, 1'b0, B_DATA, B_MASK, B_KEY);
    wait_acc(ab + 3, 60);
    set_req(0, 1'b0, 6'd1, 1'b1, A_DATA, A_MASK, A_KEY);
    set_req(1, 1'b0, 6'd3, 1'b0, B_DATA, B_MASK, B_KEY);
    wait_done(db + 3, 40);
    step(3);
    if (acc_cyc.size() >= ab + 3) begin
      chk("b2b_spacing1", acc_cyc[ab + 1] - acc_cyc[ab], 15);
      chk("b2b_spacing2", acc_cyc[ab + 2] - acc_cyc[ab + 1], 15);
    end
    load_exp_a();
    check_install("b2b_0", wb, ab, db, 0, 32'h0001_0001, 64'h1);
    load_exp_b();
    check_install("b2b_1", wb + 13, ab + 1, db + 1, 1, 32'h0001_0003, 64'h0);
    load_exp_a();
    check_install("b2b_2", wb + 26, ab + 2, db + 2, 0, 32'h0001_0001, 64'h1);

    // Out-of-range rule id: no writes, done+err one cycle after accept.
    wb = wr_addr.size(); ab = acc_cyc.size(); db = done_cyc.size(); bb = busy_cnt;
    set_req(0, 1'b1, 6'd4, 1'b1, A_DATA, A_MASK, A_KEY);
    wait_acc(ab + 1, 10);
    set_req(0, 1'b0, 6'd4, 1'b1, A_DATA, A_MASK, A_KEY);
    wait_done(db + 1, 10);
    step(3);
    chk("err_nwr", wr_addr.size(), wb);
    chk("err_busy_cycles", busy_cnt - bb, 1);
    if (done_cyc.size() > db && acc_cyc.size() > ab) begin
      chk("err_done_cyc", done_cyc[db], acc_cyc[ab] + 1);
      chk("err_flag", done_err[db], 1);
      chk("err_who", done_who[db], 0);
    end

    // Reset in the 5th write cycle aborts; a fresh request then installs fully.
    wb = wr_addr.size(); ab = acc_cyc.size(); db = done_cyc.size();
    set_req(1, 1'b1, 6'd0, 1'b1, A_DATA, A_MASK, A_KEY);
    i = 0;
    while (wr_addr.size() < wb + 5 && i < 40) begin
      @(negedge i_clk);
      #1;
      i++;
    end
    chk("rst_pre_wren", bus.o_rule_wren, 1'b1);
    i_rst = 1'b1;
    #1;
    chk_zero("rst_async");
    step(2);
    chk("rst_abort_ndone", done_cyc.size(), db);
    wb = wr_addr.size(); ab = acc_cyc.size(); db = done_cyc.size();
    i_rst = 1'b0;
    wait_acc(ab + 1, 10);
    set_req(1, 1'b0, 6'd0, 1'b1, A_DATA, A_MASK, A_KEY);
    wait_done(db + 1, 40);
    step(3);
    load_exp_a();
    check_install("rst_fresh", wb, ab, db, 1, 32'h0001_0000, 64'h1);
    chk("rst_fresh_ndone", done_cyc.size(), db + 1);

    chk("idle_outputs_nonzero", idle_nz, 0);
    chk("both_ready", both_rdy, 0);
    chk("err_without_done", stray_err, 0);
    chk_zero("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
